// File: rtl/vc_fifo_pkg.sv
// Shared types and helpers for the virtual-channel FIFO bank.
package vc_fifo_pkg;

    // Width of a VC index; a single-channel bank still carries a 1-bit index.
    function automatic int vc_width(input int num_vc);
        return (num_vc > 1) ? $clog2(num_vc) : 1;
    endfunction

    // Entries per VC for a given pointer width.
    function automatic int fifo_depth(input int address_width);
        return 1 << address_width;
    endfunction

    // Status of one virtual channel as seen by the arbiter.
    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
        logic err;
    } vc_status_t;

endpackage

// File: rtl/vc_fifo_channel.sv
// One virtual-channel FIFO: storage, pointers, occupancy count, flags and
// sticky error. Optional DROP_CNT_EN adds a saturating dropped-write counter.
module vc_fifo_channel
    import vc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 6,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_req_i,
    input  logic [DATA_WIDTH-1:0]  wr_data_i,
    input  logic                   rd_req_i,
    input  logic [ADDRESS_WIDTH:0] af_thresh_i,
    input  logic [ADDRESS_WIDTH:0] ae_thresh_i,
    input  logic                   err_clear_i,
    output logic                   rd_ok_o,
    output logic [DATA_WIDTH-1:0]  head_data_o,
`ifdef DROP_CNT_EN
    output logic [7:0]             drop_cnt_o,
`endif
    output vc_status_t             status_o
);

    localparam int                     DEPTH     = fifo_depth(ADDRESS_WIDTH);
    localparam logic [ADDRESS_WIDTH:0] DEPTH_CNT = (ADDRESS_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
    logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDRESS_WIDTH:0]   cnt_q, cnt_d;
    logic                     err_q, err_d;

    logic full, empty;
    logic wr_ok, wr_drop, rd_ok, rd_under;

    // Flags come straight from the registered count, so a write becomes
    // visible (and readable) only after the edge that stores it.
    assign full  = (cnt_q == DEPTH_CNT);
    assign empty = (cnt_q == '0);

    // A full channel drops the write even if it is being read this cycle.
    assign wr_ok    = wr_req_i && !full;
    assign wr_drop  = wr_req_i && full;
    assign rd_ok    = rd_req_i && !empty;
    assign rd_under = rd_req_i && empty;

    assign rd_ok_o     = rd_ok;
    assign head_data_o = mem_q[rd_ptr_q];

    assign status_o = '{
        full:   full,
        empty:  empty,
        afull:  (cnt_q >= af_thresh_i),
        aempty: (cnt_q <= ae_thresh_i),
        err:    err_q
    };

    // Next-state for pointers, occupancy and the sticky error.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_ok, rd_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        // Clear first so a same-cycle overflow/underflow wins.
        if (err_clear_i)         err_d = 1'b0;
        if (wr_drop || rd_under) err_d = 1'b1;
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // Entry storage; stale contents are unreachable once pointers reset.
    always_ff @(posedge clk) begin
        // NOTE: the memory has no reset so it can map onto plain RAM.
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

`ifdef DROP_CNT_EN
    logic [7:0] drop_q, drop_d;

    // Saturating count of dropped writes; err_clear restarts it.
    always_comb begin
        drop_d = drop_q;
        if (err_clear_i) drop_d = '0;
        if (wr_drop && (drop_d != 8'hFF)) drop_d = drop_d + 8'd1;
    end

    // Dropped-write counter register.
    always_ff @(posedge clk) begin
        if (reset) drop_q <= '0;
        else       drop_q <= drop_d;
    end

    assign drop_cnt_o = drop_q;
`endif

endmodule

// File: rtl/vc_fifo_bank.sv
// Bank of NUM_VC virtual-channel FIFOs behind one shared write port and one
// shared read port. Define DROP_CNT_EN to add per-VC dropped-write counters
// on the drop_cnt output.
module vc_fifo_bank
    import vc_fifo_pkg::*;
#(
    parameter int  NUM_VC        = 2,
    parameter int  DATA_WIDTH    = 6,
    parameter int  ADDRESS_WIDTH = 4,
    localparam int VC_W          = vc_width(NUM_VC)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_enable,
    input  logic [VC_W-1:0]        wr_vc,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   rd_enable,
    input  logic [VC_W-1:0]        rd_vc,
    input  logic [ADDRESS_WIDTH:0] af_thresh,
    input  logic [ADDRESS_WIDTH:0] ae_thresh,
    input  logic                   err_clear,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   data_out_valid,
    output logic [NUM_VC-1:0]      full_fifo,
    output logic [NUM_VC-1:0]      empty_fifo,
    output logic [NUM_VC-1:0]      almost_full,
    output logic [NUM_VC-1:0]      almost_empty,
`ifdef DROP_CNT_EN
    output logic [NUM_VC*8-1:0]    drop_cnt,
`endif
    output logic [NUM_VC-1:0]      error
);

    logic [NUM_VC-1:0]     wr_req;
    logic [NUM_VC-1:0]     rd_req;
    logic [NUM_VC-1:0]     rd_ok;
    logic [DATA_WIDTH-1:0] head_data [NUM_VC];
    vc_status_t            status    [NUM_VC];

    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_q;

    // Address decode: an index >= NUM_VC matches no channel, so such a
    // request is ignored with no state change and no error.
    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
        assign wr_req[g] = wr_enable && (wr_vc == VC_W'(g));
        assign rd_req[g] = rd_enable && (rd_vc == VC_W'(g));

        vc_fifo_channel #(
            .DATA_WIDTH    (DATA_WIDTH),
            .ADDRESS_WIDTH (ADDRESS_WIDTH)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .wr_req_i    (wr_req[g]),
            .wr_data_i   (data_in),
            .rd_req_i    (rd_req[g]),
            .af_thresh_i (af_thresh),
            .ae_thresh_i (ae_thresh),
            .err_clear_i (err_clear),
            .rd_ok_o     (rd_ok[g]),
            .head_data_o (head_data[g]),
`ifdef DROP_CNT_EN
            .drop_cnt_o  (drop_cnt[g*8 +: 8]),
`endif
            .status_o    (status[g])
        );

        assign full_fifo[g]    = status[g].full;
        assign empty_fifo[g]   = status[g].empty;
        assign almost_full[g]  = status[g].afull;
        assign almost_empty[g] = status[g].aempty;
        assign error[g]        = status[g].err;
    end

    // Select the head entry of the channel whose read is accepted; at most
    // one rd_ok bit is set, otherwise data_out keeps its value.
    always_comb begin
        data_out_d = data_out_q;
        for (int i = 0; i < NUM_VC; i++) begin
            if (rd_ok[i]) data_out_d = head_data[i];
        end
    end

    // Registered read data and its one-cycle valid strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            valid_q    <= |rd_ok;
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = valid_q;

endmodule

// File: tb/tb_vc_fifo_bank.sv
// Self-checking bench for vc_fifo_bank: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_vc_fifo_bank;

    localparam int NUM_VC = 2;
    localparam int DW     = 6;
    localparam int AW     = 4;
    localparam int DEPTH  = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_enable;
    logic          wr_vc;
    logic [DW-1:0] data_in;
    logic          rd_enable;
    logic          rd_vc;
    logic [AW:0]   af_thresh;
    logic [AW:0]   ae_thresh;
    logic          err_clear;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic [NUM_VC-1:0] full_fifo, empty_fifo, almost_full, almost_empty, error;
`ifdef DROP_CNT_EN
    logic [NUM_VC*8-1:0] drop_cnt;
`endif

    vc_fifo_bank #(
        .NUM_VC        (NUM_VC),
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .wr_enable      (wr_enable),
        .wr_vc          (wr_vc),
        .data_in        (data_in),
        .rd_enable      (rd_enable),
        .rd_vc          (rd_vc),
        .af_thresh      (af_thresh),
        .ae_thresh      (ae_thresh),
        .err_clear      (err_clear),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .full_fifo      (full_fifo),
        .empty_fifo     (empty_fifo),
        .almost_full    (almost_full),
        .almost_empty   (almost_empty),
`ifdef DROP_CNT_EN
        .drop_cnt       (drop_cnt),
`endif
        .error          (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one queue per VC plus the visible registered outputs.
    logic [DW-1:0]     mq [NUM_VC][$];
    logic [NUM_VC-1:0] err_m;
    logic [DW-1:0]     dout_m;
    logic              valid_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare every DUT output with what the model predicts.
    task automatic check_all(input string tag);
        logic [NUM_VC-1:0] ef, ff, af, ae;
        for (int v = 0; v < NUM_VC; v++) begin
            int sz;
            sz    = mq[v].size();
            ef[v] = (sz == 0);
            ff[v] = (sz == DEPTH);
            af[v] = (sz >= int'(af_thresh));
            ae[v] = (sz <= int'(ae_thresh));
        end
        check({tag, ".empty"},  32'(empty_fifo),     32'(ef));
        check({tag, ".full"},   32'(full_fifo),      32'(ff));
        check({tag, ".afull"},  32'(almost_full),    32'(af));
        check({tag, ".aempty"}, 32'(almost_empty),   32'(ae));
        check({tag, ".error"},  32'(error),          32'(err_m));
        check({tag, ".valid"},  32'(data_out_valid), 32'(valid_m));
        check({tag, ".dout"},   32'(data_out),       32'(dout_m));
    endtask

    // Apply one clock edge's worth of requests to the model.
    task automatic model_update(input logic we, input int wv, input logic [DW-1:0] d,
                                input logic re, input int rv, input logic clr);
        bit w_ok, w_drop, r_ok, r_under;
        w_ok    = we && (wv < NUM_VC) && (mq[wv].size() < DEPTH);
        w_drop  = we && (wv < NUM_VC) && (mq[wv].size() == DEPTH);
        r_ok    = re && (rv < NUM_VC) && (mq[rv].size() > 0);
        r_under = re && (rv < NUM_VC) && (mq[rv].size() == 0);
        valid_m = r_ok;
        if (r_ok) dout_m = mq[rv].pop_front();
        if (w_ok) mq[wv].push_back(d);
        if (clr) err_m = '0;
        if (w_drop)  err_m[wv] = 1'b1;
        if (r_under) err_m[rv] = 1'b1;
    endtask

    task automatic step(input string tag, input logic we, input int wv, input logic [DW-1:0] d,
                        input logic re, input int rv, input logic clr);
        @(negedge clk);
        wr_enable = we;
        wr_vc     = wv[0];
        data_in   = d;
        rd_enable = re;
        rd_vc     = rv[0];
        err_clear = clr;
        @(posedge clk);
        model_update(we, wv, d, re, rv, clr);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag, input int ncyc);
        @(negedge clk);
        reset     = 1'b1;
        wr_enable = 1'b0;
        rd_enable = 1'b0;
        err_clear = 1'b0;
        repeat (ncyc) @(posedge clk);
        #1;
        for (int v = 0; v < NUM_VC; v++) mq[v].delete();
        err_m   = '0;
        dout_m  = '0;
        valid_m = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check_all(tag);
    endtask

    // Watchdog: the bench must never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        wr_enable = 1'b0;
        wr_vc     = 1'b0;
        data_in   = '0;
        rd_enable = 1'b0;
        rd_vc     = 1'b0;
        err_clear = 1'b0;
        af_thresh = 5'd16;
        ae_thresh = 5'd0;
        err_m     = '0;
        dout_m    = '0;
        valid_m   = 1'b0;

        // 1. Reset state.
        do_reset("t1_reset", 2);
        check("t1_empty_const", 32'(empty_fifo), 32'h3);

        // 2. Fill VC0 with 0x01..0x10, then overflow it.
        for (int i = 1; i <= DEPTH; i++) step("t2_fill", 1'b1, 0, DW'(i), 1'b0, 0, 1'b0);
        check("t2_full0", 32'(full_fifo[0]), 32'd1);
        step("t2_ovf", 1'b1, 0, 6'h3F, 1'b0, 0, 1'b0);
        check("t2_err0", 32'(error), 32'h1);

        // 3. Drain VC0 in order, then one rejected read.
        for (int i = 1; i <= DEPTH; i++) begin
            step("t3_drain", 1'b0, 0, '0, 1'b1, 0, 1'b0);
            check("t3_order", 32'(data_out), 32'(i));
        end
        step("t3_under", 1'b0, 0, '0, 1'b1, 0, 1'b0);
        check("t3_valid_low", 32'(data_out_valid), 32'd0);
        step("t3_clr", 1'b0, 0, '0, 1'b0, 0, 1'b1);

        // 4. Concurrent traffic on different VCs, then same-VC write+read.
        af_thresh = 5'd2;
        ae_thresh = 5'd2;
        for (int i = 0; i < 3; i++) step("t4_pre", 1'b1, 0, DW'(8 + i), 1'b0, 0, 1'b0);
        step("t4_cross", 1'b1, 1, 6'h21, 1'b1, 0, 1'b0);
        step("t4_same", 1'b1, 0, 6'h22, 1'b1, 0, 1'b0);
        check("t4_vc0_afull", 32'(almost_full[0]), 32'd1);

        // 5. Threshold behaviour on VC1.
        do_reset("t5_reset", 1);
        af_thresh = 5'd14;
        ae_thresh = 5'd2;
        for (int i = 1; i <= 14; i++) begin
            step("t5_fill", 1'b1, 1, DW'($urandom), 1'b0, 0, 1'b0);
            if (i == 2)  check("t5_ae_hold", 32'(almost_empty[1]), 32'd1);
            if (i == 3)  check("t5_ae_fall", 32'(almost_empty[1]), 32'd0);
            if (i == 13) check("t5_af_low",  32'(almost_full[1]),  32'd0);
            if (i == 14) check("t5_af_rise", 32'(almost_full[1]),  32'd1);
        end

        // 6a. err_clear in the same cycle as an overflow: set wins.
        for (int i = 0; i < DEPTH; i++) step("t6_fill", 1'b1, 0, DW'($urandom), 1'b0, 0, 1'b0);
        step("t6_ovf_clr", 1'b1, 0, 6'h15, 1'b0, 0, 1'b1);
        check("t6_set_wins", 32'(error[0]), 32'd1);
        step("t6_clr", 1'b0, 0, '0, 1'b0, 0, 1'b1);

        // 6b. Pointer wrap over 40 writes/reads on VC0.
        do_reset("t6_reset", 1);
        for (int i = 0; i < 40; i++)
            step("t6_wrap", 1'b1, 0, DW'($urandom), (i >= 3), 0, 1'b0);
        for (int i = 0; i < 4; i++) step("t6_wdrain", 1'b0, 0, '0, 1'b1, 0, 1'b0);

        // 6c. Reset with queued data discards it.
        for (int i = 0; i < 5; i++) step("t6_q5", 1'b1, 0, DW'($urandom), 1'b0, 0, 1'b0);
        do_reset("t6_rst5", 1);
        check("t6_empty0", 32'(empty_fifo[0]), 32'd1);

        // 7. Randomized traffic: write-heavy, then read-heavy phases.
        for (int i = 0; i < 600; i++) begin
            logic we, re, clr;
            if (i % 50 == 0) begin
                af_thresh = AW'($urandom_range(0, DEPTH)) | 5'd0;
                af_thresh = 5'($urandom_range(0, DEPTH));
                ae_thresh = 5'($urandom_range(0, DEPTH));
            end
            if ((i / 150) % 2 == 0) begin
                we = ($urandom_range(0, 3) != 0);
                re = ($urandom_range(0, 3) == 0);
            end else begin
                we = ($urandom_range(0, 3) == 0);
                re = ($urandom_range(0, 3) != 0);
            end
            clr = ($urandom_range(0, 15) == 0);
            step("t7_rand", we, int'($urandom_range(0, NUM_VC - 1)), DW'($urandom),
                 re, int'($urandom_range(0, NUM_VC - 1)), clr);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
